hamming74_decode_arbiter: RTL and testbench

//  Shares one serial Hamming(7,4) decoder between NUM_REQ requesters using round-robin arbitration.
//  For the granted requester it latches that requester's 7-bit codeword and shifts it into the decoder LSB first.
//  It then collects the decoded nibble and syndrome and returns them with the requester id.
//  It detects a decoder that never asserts valid, re-synchronises it via its active-low reset, and reports a timeout.

---
 rtl/hamming74_pkg.sv | 19 +
 rtl/hamming74_decode_arbiter_if.sv | 49 ++++
 rtl/hamming74_decode_arbiter_rr_arbiter.sv | 36 +++
 rtl/hamming74_decode_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_hamming74_decode_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming74_pkg.sv
// Shared constants and FSM encoding for the Hamming(7,4) decode arbiter.
// Codeword, nibble and syndrome widths, plus the controller state set.
package hamming74_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DECODE,
    WAIT,
    RECOVER,
    RESP
  } state_e;

endpackage

// File: rtl/hamming74_decode_arbiter_if.sv
// Requester, decoder and response signals of the decode arbiter.
// The arbiter takes the slave view; the environment takes the master view.
interface hamming74_decode_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import hamming74_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req;
  logic [CW_W*NUM_REQ-1:0] codeword_in;
  logic [NUM_REQ-1:0]      grant;

  logic              dec_rst_n;
  logic              dec_ena;
  logic              dec_bit;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_data;
  logic [SYN_W-1:0]  dec_syndrome;

  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [SYN_W-1:0]  rsp_syndrome;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;

  modport slave (
    input  req, codeword_in,
    input  dec_valid, dec_data, dec_syndrome,
    output grant,
    output dec_rst_n, dec_ena, dec_bit,
    output rsp_valid, rsp_id, rsp_data,
    output rsp_syndrome, rsp_err, rsp_timeout,
    output busy
  );

  modport master (
    output req, codeword_in,
    output dec_valid, dec_data, dec_syndrome,
    input  grant,
    input  dec_rst_n, dec_ena, dec_bit,
    input  rsp_valid, rsp_id, rsp_data,
    input  rsp_syndrome, rsp_err, rsp_timeout,
    input  busy
  );

endinterface

// File: rtl/hamming74_decode_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  int   j;
  logic hit;

  // scan NUM_REQ slots starting at ptr, keep the first hit
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    j   = 0;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      hit = |(req & (NUM_REQ'(1) << j));
      if (!any && hit) begin
        any = 1'b1;
        gnt = NUM_REQ'(1) << j;
        id  = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/hamming74_decode_arbiter.sv
// Shares one serial Hamming(7,4) decoder between requesters (round robin),
// shifts the codeword in, collects the result, recovers a silent decoder.
module hamming74_decode_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT        = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  hamming74_decode_arbiter_if.slave bus
);
  import hamming74_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [2:0]          idx_q, idx_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;
  logic                dec_rst_n_q, dec_rst_n_d;
  logic                dec_ena_q, dec_ena_d;
  logic                dec_bit_q, dec_bit_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [SYN_W-1:0]    rsp_syn_q, rsp_syn_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_to_q, rsp_to_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;
  logic [CW_W-1:0]     cw_sel;
  logic [2:0]          idx_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  assign cw_sel  = CW_W'(bus.codeword_in >> (CW_W * int'(id_q)));
  assign idx_nxt = idx_q + 3'd1;

  // next-state and next-output logic; outputs are set for the state entered
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    grant_d     = grant_q;
    cw_d        = cw_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    dec_rst_n_d = dec_rst_n_q;
    dec_ena_d   = dec_ena_q;
    dec_bit_d   = dec_bit_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_syn_d   = rsp_syn_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    unique case (state_q)
      IDLE: begin
        dec_rst_n_d = 1'b1;
        dec_ena_d   = 1'b0;
        dec_bit_d   = 1'b0;
        if (arb_any) begin
          grant_d = arb_gnt;
          id_d    = arb_id;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cw_d      = cw_sel;
        idx_d     = 3'd0;
        dec_ena_d = 1'b1;
        dec_bit_d = cw_sel[0];
        state_d   = SHIFT;
      end
      SHIFT: begin
        dec_ena_d = 1'b1;
        if (idx_q == 3'd6) begin
          dec_bit_d = 1'b0;
          state_d   = DECODE;
        end else begin
          idx_d     = idx_nxt;
          dec_bit_d = cw_q[idx_nxt];
        end
      end
      DECODE: begin
        dec_ena_d = 1'b0;
        dec_bit_d = 1'b0;
        wcnt_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.dec_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = bus.dec_data;
          rsp_syn_d   = bus.dec_syndrome;
          rsp_err_d   = |bus.dec_syndrome;
          rsp_to_d    = 1'b0;
          state_d     = RESP;
        end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
          dec_rst_n_d = 1'b0;
          rcnt_d      = '0;
          state_d     = RECOVER;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (rcnt_q == RC_W'(RECOVER_CYCLES - 1)) begin
          dec_rst_n_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_syn_d   = '0;
          rsp_err_d   = 1'b0;
          rsp_to_d    = 1'b1;
          state_d     = RESP;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RESP: begin
        grant_d = '0;
        ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // all state and outputs registered; async reset holds the decoder in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      grant_q     <= '0;
      cw_q        <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      dec_rst_n_q <= 1'b0;
      dec_ena_q   <= 1'b0;
      dec_bit_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_syn_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      grant_q     <= grant_d;
      cw_q        <= cw_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      dec_rst_n_q <= dec_rst_n_d;
      dec_ena_q   <= dec_ena_d;
      dec_bit_q   <= dec_bit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_syn_q   <= rsp_syn_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.dec_rst_n    = dec_rst_n_q;
  assign bus.dec_ena      = dec_ena_q;
  assign bus.dec_bit      = dec_bit_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_syndrome = rsp_syn_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_timeout  = rsp_to_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_hamming74_decode_arbiter.sv
// Bench for hamming74_decode_arbiter: decoder model, response scoreboard,
// vector table of single transactions, and hand-written corner sequences.
module tb_hamming74_decode_arbiter;

  localparam int NR = 4;
  localparam int TO = 4;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hamming74_decode_arbiter_if #(.NUM_REQ(NR)) bus();

  hamming74_decode_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT        (TO),
    .RECOVER_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
    logic       to;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] data;
    logic [2:0] syn;
    bit         mute;
    int         delay;
    int         eid;
    bit         eto;
    int         elat;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[11];
  logic [6:0] cw[NR];

  int checks   = 0;
  int failures = 0;
  int rsp_seen = 0;
  int cyc      = 0;

  logic [3:0] m_data  = 4'h0;
  logic [2:0] m_syn   = 3'd0;
  bit         m_mute  = 1'b0;
  int         m_delay = 0;
  int         inj_req = 0;
  logic [6:0] m_rx    = 7'd0;
  int         m_tot   = 0;

  // serial decoder model: 8 enables, then a valid pulse after m_delay cycles
  initial begin : model
    int   cnt;
    int   dly;
    int   inj_done;
    bit   armed;
    logic s_ena, s_bit, s_rstn;
    cnt = 0; dly = 0; inj_done = 0; armed = 1'b0;
    bus.dec_valid    = 1'b0;
    bus.dec_data     = 4'h0;
    bus.dec_syndrome = 3'd0;
    forever begin
      @(posedge clk);
      s_ena  = bus.dec_ena;
      s_bit  = bus.dec_bit;
      s_rstn = bus.dec_rst_n;
      #1;
      bus.dec_valid = 1'b0;
      if (rst || !s_rstn) begin
        cnt   = 0;
        armed = 1'b0;
      end else begin
        if (armed) begin
          if (dly == 0) begin
            bus.dec_valid    = 1'b1;
            bus.dec_data     = m_data;
            bus.dec_syndrome = m_syn;
            armed = 1'b0;
          end else dly--;
        end
        if (s_ena) begin
          if (cnt < 7) m_rx = {s_bit, m_rx[6:1]};
          cnt++;
          m_tot++;
          if (cnt == 8) begin
            cnt = 0;
            if (!m_mute) begin
              if (m_delay == 0) begin
                bus.dec_valid    = 1'b1;
                bus.dec_data     = m_data;
                bus.dec_syndrome = m_syn;
              end else begin
                armed = 1'b1;
                dly   = m_delay - 1;
              end
            end
          end
        end
      end
      if (inj_req != inj_done) begin
        inj_done      = inj_req;
        bus.dec_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // one cycle; scoreboard pops and compares on every response strobe
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
    if (bus.rsp_valid) begin
      rsp_seen++;
      chk("rsp_expected", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_syndrome", bus.rsp_syndrome, e.syn);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_timeout", bus.rsp_timeout, e.to);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin tick(); n++; end
    chk("idle_wait", bus.busy, 0);
  endtask

  task automatic wait_grant(input logic [3:0] eg);
    int n;
    n = 0;
    while (bus.grant == 0 && n < 8) begin tick(); n++; end
    chk("grant", bus.grant, eg);
  endtask

  // one full transaction from IDLE, req dropped once granted
  task automatic do_txn(input logic [3:0] r, input logic [3:0] d,
                        input logic [2:0] s, input bit mute, input int dly,
                        input int eid, input bit eto, input int elat);
    exp_t e;
    int   e0, n0, lat, low;
    wait_idle();
    m_data = d; m_syn = s; m_mute = mute; m_delay = dly;
    e.id   = eid;
    e.data = eto ? 4'h0 : d;
    e.syn  = eto ? 3'd0 : s;
    e.err  = eto ? 1'b0 : (s != 3'd0);
    e.to   = eto;
    sbq.push_back(e);
    e0 = m_tot;
    bus.req = r;
    wait_grant(4'(1 << eid));
    bus.req = 4'b0;
    n0 = rsp_seen; lat = 0; low = 0;
    while (rsp_seen == n0 && lat < 60) begin
      tick();
      lat++;
      if (!bus.dec_rst_n) low++;
    end
    chk("latency", lat, elat);
    chk("serial_bits", m_rx, cw[eid]);
    chk("ena_pulses", m_tot - e0, 8);
    chk("recover_low_cycles", low, eto ? RC : 0);
  endtask

  initial begin : main
    int n0, n, last;
    exp_t e;
    cw[0] = 7'b1010101;
    cw[1] = 7'b1100110;
    cw[2] = 7'b0111000;
    cw[3] = 7'b1001011;
    bus.req = 4'b0;
    bus.codeword_in = {cw[3], cw[2], cw[1], cw[0]};

    tv[0]  = '{4'b0001, 4'hB, 3'd0, 1'b0, 0, 0, 1'b0, 10};
    tv[1]  = '{4'b0001, 4'h3, 3'd5, 1'b0, 0, 0, 1'b0, 10};
    tv[2]  = '{4'b1001, 4'h6, 3'd0, 1'b0, 0, 3, 1'b0, 10};
    tv[3]  = '{4'b1001, 4'hA, 3'd7, 1'b0, 0, 0, 1'b0, 10};
    tv[4]  = '{4'b0110, 4'h1, 3'd0, 1'b0, 0, 1, 1'b0, 10};
    tv[5]  = '{4'b0110, 4'h2, 3'd1, 1'b0, 0, 2, 1'b0, 10};
    tv[6]  = '{4'b0010, 4'hF, 3'd2, 1'b1, 0, 1, 1'b1, 15};
    tv[7]  = '{4'b1000, 4'h7, 3'd0, 1'b0, 0, 3, 1'b0, 10};
    tv[8]  = '{4'b0100, 4'hC, 3'd0, 1'b0, 3, 2, 1'b0, 13};
    tv[9]  = '{4'b0100, 4'hD, 3'd4, 1'b0, 4, 2, 1'b1, 15};
    tv[10] = '{4'b1111, 4'hE, 3'd0, 1'b0, 2, 3, 1'b0, 12};

    tick();
    tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_dec_rst_n", bus.dec_rst_n, 0);
    chk("rst_dec_ena", bus.dec_ena, 0);
    chk("rst_dec_bit", bus.dec_bit, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_fields",
        {bus.rsp_id, bus.rsp_data, bus.rsp_syndrome,
         bus.rsp_err, bus.rsp_timeout}, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_dec_rst_n", bus.dec_rst_n, 1);

    for (int i = 0; i < 11; i++)
      do_txn(tv[i].req, tv[i].data, tv[i].syn, tv[i].mute, tv[i].delay,
             tv[i].eid, tv[i].eto, tv[i].elat);

    // all requesters held: 0,1,2,3,0 at 12-cycle spacing
    wait_idle();
    m_data = 4'h9; m_syn = 3'd0; m_mute = 1'b0; m_delay = 0;
    for (int i = 0; i < 5; i++) begin
      e = '{i % 4, 4'h9, 3'd0, 1'b0, 1'b0};
      sbq.push_back(e);
    end
    n0 = rsp_seen; n = 0; last = -1;
    bus.req = 4'b1111;
    while (rsp_seen - n0 < 5 && n < 100) begin
      tick();
      n++;
      if (bus.rsp_valid) begin
        if (last >= 0) chk("rr_spacing", cyc - last, 12);
        last = cyc;
        if (rsp_seen - n0 == 5) bus.req = 4'b0;
      end
    end
    chk("rr_count", rsp_seen - n0, 5);

    // reset mid-SHIFT with pointer at 3, then pointer must restart at 0
    do_txn(4'b0100, 4'h4, 3'd0, 1'b0, 0, 2, 1'b0, 10);
    wait_idle();
    bus.req = 4'b1000;
    wait_grant(4'b1000);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("abort_grant", bus.grant, 0);
    chk("abort_dec_rst_n", bus.dec_rst_n, 0);
    chk("abort_dec_ena", bus.dec_ena, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rsp_data", bus.rsp_data, 0);
    bus.req = 4'b0;
    tick();
    tick();
    rst = 1'b0;
    n0 = rsp_seen;
    repeat (4) tick();
    chk("abort_no_rsp", rsp_seen - n0, 0);
    chk("abort_dec_rst_n_rel", bus.dec_rst_n, 1);
    do_txn(4'b1001, 4'h5, 3'd0, 1'b0, 0, 0, 1'b0, 10);
    do_txn(4'b0100, 4'h6, 3'd3, 1'b0, 0, 2, 1'b0, 10);

    // req dropped in SHIFT, stray valids in SHIFT and IDLE
    wait_idle();
    m_data = 4'h8; m_syn = 3'd0; m_mute = 1'b0; m_delay = 0;
    e = '{1, 4'h8, 3'd0, 1'b0, 1'b0};
    sbq.push_back(e);
    n0 = rsp_seen;
    bus.req = 4'b0010;
    wait_grant(4'b0010);
    tick();
    tick();
    bus.req = 4'b0;
    inj_req++;
    n = 0;
    while (rsp_seen == n0 && n < 40) begin tick(); n++; end
    chk("drop_rsp_issued", rsp_seen - n0, 1);
    wait_idle();
    inj_req++;
    n0 = rsp_seen;
    repeat (6) tick();
    chk("idle_valid_ignored", rsp_seen - n0, 0);
    chk("idle_busy", bus.busy, 0);
    chk("hold_rsp_data", bus.rsp_data, 4'h8);
    chk("hold_rsp_id", bus.rsp_id, 1);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
